// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage load/store sequencer with ack timeout and write-back register
// Updates on negedge clk to match the surrounding pipeline stage registers.
module mem_access_ctrl #(
   parameter int ACK_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        Mem_Read_in,
   input  logic        Mem_Write_in,
   input  logic        Mem_to_Reg_in,
   input  logic        Reg_Write_in,
   input  logic [4:0]  RD_in,
   input  logic [31:0] ALU_Result_in,
   input  logic [31:0] B_in,
   input  logic [2:0]  funct3_in,
   output logic        stall,
   output logic        fault,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        WB_Reg_Write,
   output logic        WB_Mem_to_Reg,
   output logic [4:0]  WB_RD,
   output logic [31:0] WB_data
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]  r_state;
   logic [7:0]  r_cnt;
   logic        r_timeout;
   logic [31:0] r_addr;
   logic [1:0]  r_off;
   logic [31:0] r_wdata;
   logic [3:0]  r_be;
   logic        r_we;
   logic        r_load;
   logic        r_mem_to_reg;
   logic        r_reg_write;
   logic [4:0]  r_rd;
   logic [2:0]  r_f3;
   logic [31:0] r_ldata;

   logic        w_access;
   logic        w_f3_legal;
   logic        w_illegal;
   logic        w_misal;
   logic        w_start;
   logic        w_bad;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_lane;
   logic [31:0] w_ext;

   assign w_access   = Mem_Read_in ^ Mem_Write_in;
   assign w_f3_legal = (funct3_in == 3'b000) || (funct3_in == 3'b001) || (funct3_in == 3'b010) ||
                       (funct3_in == 3'b100) || (funct3_in == 3'b101);
   // funct3 only has meaning as an access size when the op touches memory
   assign w_illegal  = (Mem_Read_in & Mem_Write_in) | (w_access & ~w_f3_legal);
   assign w_misal    = w_access & (((funct3_in[1:0] == 2'b01) & ALU_Result_in[0]) |
                                   ((funct3_in == 3'b010) & (ALU_Result_in[1:0] != 2'b00)));
   assign w_start    = (r_state == IDLE) & w_access & ~w_illegal & ~w_misal;
   assign w_bad      = (r_state == IDLE) & (w_illegal | w_misal);

   assign stall   = ~rst & (w_start | (r_state == BUSY));
   assign fault   = ~rst & (w_bad | ((r_state == DONE) & r_timeout));
   assign mem_req = (r_state == BUSY);
   assign mem_we  = (r_state == BUSY) & r_we;
   assign mem_be  = (r_state == BUSY) ? r_be : 4'b0000;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = B_in;
      case (funct3_in[1:0])
         2'b00: begin
            w_be    = 4'b0001 << ALU_Result_in[1:0];
            w_wdata = {4{B_in[7:0]}};
         end
         2'b01: begin
            w_be    = 4'b0011 << ALU_Result_in[1:0];
            w_wdata = {2{B_in[15:0]}};
         end
         default: ;
      endcase
   end

   assign w_lane = mem_rdata >> {r_off, 3'b000};

   always_comb begin
      w_ext = mem_rdata;
      case (r_f3)
         3'b000:  w_ext = {{24{w_lane[7]}}, w_lane[7:0]};
         3'b100:  w_ext = {24'd0, w_lane[7:0]};
         3'b001:  w_ext = {{16{w_lane[15]}}, w_lane[15:0]};
         3'b101:  w_ext = {16'd0, w_lane[15:0]};
         default: w_ext = mem_rdata;
      endcase
   end

   always_ff @(negedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_cnt         <= 8'd0;
         r_timeout     <= 1'b0;
         r_addr        <= 32'd0;
         r_off         <= 2'd0;
         r_wdata       <= 32'd0;
         r_be          <= 4'd0;
         r_we          <= 1'b0;
         r_load        <= 1'b0;
         r_mem_to_reg  <= 1'b0;
         r_reg_write   <= 1'b0;
         r_rd          <= 5'd0;
         r_f3          <= 3'd0;
         r_ldata       <= 32'd0;
         WB_Reg_Write  <= 1'b0;
         WB_Mem_to_Reg <= 1'b0;
         WB_RD         <= 5'd0;
         WB_data       <= 32'd0;
      end else begin
         // Bubble by default; only a pass-through op or a completed load overrides it
         WB_Reg_Write  <= 1'b0;
         WB_Mem_to_Reg <= 1'b0;
         WB_RD         <= 5'd0;
         WB_data       <= 32'd0;
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_addr       <= ALU_Result_in & ~32'd3;
                  r_off        <= ALU_Result_in[1:0];
                  r_wdata      <= w_wdata;
                  r_be         <= w_be;
                  r_we         <= Mem_Write_in;
                  r_load       <= Mem_Read_in;
                  r_mem_to_reg <= Mem_to_Reg_in;
                  r_reg_write  <= Reg_Write_in;
                  r_rd         <= RD_in;
                  r_f3         <= funct3_in;
                  r_cnt        <= 8'd0;
                  r_timeout    <= 1'b0;
                  r_state      <= BUSY;
               end else if (!w_bad) begin
                  WB_Reg_Write  <= Reg_Write_in;
                  WB_Mem_to_Reg <= Mem_to_Reg_in;
                  WB_RD         <= RD_in;
                  WB_data       <= ALU_Result_in;
               end
            end
            BUSY: begin
               if (mem_ack) begin
                  r_ldata <= w_ext;
                  r_state <= DONE;
               end else if (r_cnt == 8'(ACK_TIMEOUT - 1)) begin
                  r_timeout <= 1'b1;
                  r_state   <= DONE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            DONE: begin
               if (r_load && !r_timeout) begin
                  WB_Reg_Write  <= r_reg_write;
                  WB_Mem_to_Reg <= r_mem_to_reg;
                  WB_RD         <= r_rd;
                  WB_data       <= r_ldata;
               end
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
// Inputs change and outputs are sampled just after posedge; the DUT updates on negedge.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        Mem_Read_in, Mem_Write_in, Mem_to_Reg_in, Reg_Write_in;
   logic [4:0]  RD_in;
   logic [31:0] ALU_Result_in, B_in;
   logic [2:0]  funct3_in;
   logic        stall, fault, mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic        WB_Reg_Write, WB_Mem_to_Reg;
   logic [4:0]  WB_RD;
   logic [31:0] WB_data;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_access_ctrl #(.ACK_TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .Mem_Read_in(Mem_Read_in), .Mem_Write_in(Mem_Write_in),
      .Mem_to_Reg_in(Mem_to_Reg_in), .Reg_Write_in(Reg_Write_in),
      .RD_in(RD_in), .ALU_Result_in(ALU_Result_in), .B_in(B_in), .funct3_in(funct3_in),
      .stall(stall), .fault(fault), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .WB_Reg_Write(WB_Reg_Write), .WB_Mem_to_Reg(WB_Mem_to_Reg), .WB_RD(WB_RD), .WB_data(WB_data)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      Mem_Read_in = 0; Mem_Write_in = 0; Mem_to_Reg_in = 0; Reg_Write_in = 0;
      RD_in = 0; ALU_Result_in = 0; B_in = 0; funct3_in = 0;
   endtask

   task automatic run_load(input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, output logic [31:0] wb);
      tick();
      Mem_Read_in = 1; Mem_to_Reg_in = 1; Reg_Write_in = 1; RD_in = 5'd2;
      funct3_in = f3; ALU_Result_in = addr;
      tick();
      clear_in();
      mem_ack = 1; mem_rdata = rdata;
      tick();
      mem_ack = 0;
      tick();
      wb = WB_data;
   endtask

   task automatic test_reset();
      rst = 1; clear_in(); mem_ack = 0; mem_rdata = 0;
      repeat (2) @(negedge clk);
      tick();
      Mem_Read_in = 1;
      #1;
      n_tests++;
      if ({stall, fault, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
           WB_Reg_Write, WB_Mem_to_Reg, WB_RD, WB_data} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: stall=%b fault=%b req=%b addr=%h wb=%h, required all 0",
                  stall, fault, mem_req, mem_addr, WB_data);
      end
      clear_in();
      rst = 0;
   endtask

   task automatic test_alu_op();
      tick();
      Reg_Write_in = 1; RD_in = 5'd5; ALU_Result_in = 32'h12345678;
      #1;
      n_tests++;
      if (stall !== 1'b0) begin
         n_fail++; $display("FAIL alu_stall: got %b, required 0", stall);
      end
      tick();
      clear_in();
      n_tests++;
      if (WB_data !== 32'h12345678 || WB_RD !== 5'd5 || WB_Reg_Write !== 1'b1 || stall !== 1'b0) begin
         n_fail++;
         $display("FAIL alu_wb: data=%h rd=%0d rw=%b stall=%b, required 12345678 5 1 0",
                  WB_data, WB_RD, WB_Reg_Write, stall);
      end
   endtask

   task automatic test_lb();
      tick();
      Mem_Read_in = 1; Mem_to_Reg_in = 1; Reg_Write_in = 1; RD_in = 5'd7;
      funct3_in = 3'b000; ALU_Result_in = 32'h103;
      #1;
      n_tests++;
      if (stall !== 1'b1 || mem_req !== 1'b0) begin
         n_fail++; $display("FAIL lb_idle: stall=%b req=%b, required 1 0", stall, mem_req);
      end
      tick();
      clear_in();
      mem_ack = 1; mem_rdata = 32'h80FF1234;
      #1;
      n_tests++;
      if (stall !== 1'b1 || mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin
         n_fail++;
         $display("FAIL lb_busy: stall=%b req=%b we=%b addr=%h, required 1 1 0 00000100",
                  stall, mem_req, mem_we, mem_addr);
      end
      tick();
      mem_ack = 0;
      #1;
      n_tests++;
      if (stall !== 1'b0 || fault !== 1'b0 || mem_req !== 1'b0) begin
         n_fail++; $display("FAIL lb_done: stall=%b fault=%b req=%b, required 0 0 0", stall, fault, mem_req);
      end
      tick();
      n_tests++;
      if (WB_data !== 32'hFFFFFF80 || WB_Reg_Write !== 1'b1 || WB_Mem_to_Reg !== 1'b1 || WB_RD !== 5'd7) begin
         n_fail++;
         $display("FAIL lb_wb: data=%h rw=%b m2r=%b rd=%0d, required ffffff80 1 1 7",
                  WB_data, WB_Reg_Write, WB_Mem_to_Reg, WB_RD);
      end
   endtask

   task automatic test_load_ext();
      logic [2:0]  f3  [8] = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b101, 3'b001, 3'b010, 3'b100};
      logic [31:0] ad  [8] = '{32'h103, 32'h103, 32'h100, 32'h102, 32'h102, 32'h100, 32'h100, 32'h101};
      logic [31:0] exp [8] = '{32'hFFFFFF80, 32'h00000080, 32'h00000034, 32'hFFFF80FF,
                               32'h000080FF, 32'h00001234, 32'h80FF1234, 32'h00000012};
      logic [31:0] wb;
      for (int i = 0; i < 8; i++) begin
         run_load(f3[i], ad[i], 32'h80FF1234, wb);
         n_tests++;
         if (wb !== exp[i]) begin
            n_fail++;
            $display("FAIL load_ext[%0d]: f3=%b addr=%h got %h, required %h", i, f3[i], ad[i], wb, exp[i]);
         end
      end
   endtask

   task automatic test_store();
      logic [2:0]  f3  [4] = '{3'b001, 3'b000, 3'b010, 3'b001};
      logic [31:0] ad  [4] = '{32'h102, 32'h101, 32'h104, 32'h100};
      logic [31:0] bd  [4] = '{32'h0000ABCD, 32'h12345678, 32'h12345678, 32'h1234FFEE};
      logic [3:0]  ebe [4] = '{4'b1100, 4'b0010, 4'b1111, 4'b0011};
      logic [31:0] ewd [4] = '{32'hABCDABCD, 32'h78787878, 32'h12345678, 32'hFFEEFFEE};
      logic [31:0] ead [4] = '{32'h100, 32'h100, 32'h104, 32'h100};
      for (int i = 0; i < 4; i++) begin
         tick();
         Mem_Write_in = 1; funct3_in = f3[i]; ALU_Result_in = ad[i]; B_in = bd[i];
         tick();
         clear_in();
         #1;
         n_tests++;
         if (mem_be !== ebe[i] || mem_wdata !== ewd[i] || mem_we !== 1'b1 || mem_addr !== ead[i]) begin
            n_fail++;
            $display("FAIL store[%0d]: be=%b wdata=%h we=%b addr=%h, required %b %h 1 %h",
                     i, mem_be, mem_wdata, mem_we, mem_addr, ebe[i], ewd[i], ead[i]);
         end
         mem_ack = 1;
         tick();
         mem_ack = 0;
         tick();
         n_tests++;
         if (WB_Reg_Write !== 1'b0 || WB_data !== 32'd0 || mem_we !== 1'b0 || mem_be !== 4'd0) begin
            n_fail++;
            $display("FAIL store_wb[%0d]: rw=%b data=%h we=%b be=%b, required 0 0 0 0",
                     i, WB_Reg_Write, WB_data, mem_we, mem_be);
         end
      end
   endtask

   task automatic test_fault();
      logic        rd [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic        wr [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [2:0]  f3 [5] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b010};
      logic [31:0] ad [5] = '{32'h101, 32'h103, 32'h100, 32'h100, 32'h102};
      for (int i = 0; i < 5; i++) begin
         tick();
         Reg_Write_in = 1; RD_in = 5'd9; ALU_Result_in = 32'hDEAD0001;
         tick();
         Mem_Read_in = rd[i]; Mem_Write_in = wr[i]; funct3_in = f3[i];
         ALU_Result_in = ad[i]; Mem_to_Reg_in = rd[i];
         #1;
         n_tests++;
         if (fault !== 1'b1 || stall !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_pulse[%0d]: fault=%b stall=%b req=%b, required 1 0 0", i, fault, stall, mem_req);
         end
         tick();
         clear_in();
         #1;
         n_tests++;
         if (fault !== 1'b0 || mem_req !== 1'b0 || WB_Reg_Write !== 1'b0 || WB_Mem_to_Reg !== 1'b0 ||
             WB_RD !== 5'd0 || WB_data !== 32'd0) begin
            n_fail++;
            $display("FAIL fault_wb[%0d]: fault=%b req=%b rw=%b rd=%0d data=%h, required all 0",
                     i, fault, mem_req, WB_Reg_Write, WB_RD, WB_data);
         end
      end
   endtask

   task automatic test_timeout();
      int busy = 0;
      tick();
      Mem_Read_in = 1; Mem_to_Reg_in = 1; Reg_Write_in = 1; RD_in = 5'd3;
      funct3_in = 3'b010; ALU_Result_in = 32'h200;
      tick();
      clear_in();
      while (mem_req === 1'b1 && busy < 40) begin
         busy++;
         tick();
      end
      n_tests++;
      if (busy != 16) begin
         n_fail++; $display("FAIL timeout_busy_cycles: got %0d, required 16", busy);
      end
      n_tests++;
      if (fault !== 1'b1 || stall !== 1'b0) begin
         n_fail++; $display("FAIL timeout_done: fault=%b stall=%b, required 1 0", fault, stall);
      end
      mem_ack = 1; mem_rdata = 32'h55AA55AA;
      tick();
      n_tests++;
      if (fault !== 1'b0 || stall !== 1'b0 || mem_req !== 1'b0 || WB_Reg_Write !== 1'b0 || WB_data !== 32'd0) begin
         n_fail++;
         $display("FAIL timeout_after: fault=%b stall=%b req=%b rw=%b data=%h, required 0 0 0 0 0",
                  fault, stall, mem_req, WB_Reg_Write, WB_data);
      end
      tick();
      mem_ack = 0;
      n_tests++;
      if (mem_req !== 1'b0 || WB_Reg_Write !== 1'b0) begin
         n_fail++; $display("FAIL late_ack: req=%b rw=%b, required 0 0", mem_req, WB_Reg_Write);
      end
   endtask

   task automatic test_reset_busy();
      logic [31:0] wb;
      tick();
      Mem_Read_in = 1; Mem_to_Reg_in = 1; Reg_Write_in = 1; RD_in = 5'd4;
      funct3_in = 3'b010; ALU_Result_in = 32'h300;
      tick();
      clear_in();
      tick();
      tick();
      n_tests++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin
         n_fail++; $display("FAIL rst_busy_pre: req=%b addr=%h, required 1 00000300", mem_req, mem_addr);
      end
      rst = 1;
      tick();
      rst = 0;
      #1;
      n_tests++;
      if ({stall, fault, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
           WB_Reg_Write, WB_Mem_to_Reg, WB_RD, WB_data} !== '0) begin
         n_fail++;
         $display("FAIL rst_busy_outputs: req=%b addr=%h stall=%b wb=%h, required all 0",
                  mem_req, mem_addr, stall, WB_data);
      end
      tick();
      n_tests++;
      if (fault !== 1'b0 || WB_Reg_Write !== 1'b0 || mem_req !== 1'b0) begin
         n_fail++; $display("FAIL rst_busy_abandon: fault=%b rw=%b req=%b, required 0 0 0", fault, WB_Reg_Write, mem_req);
      end
      run_load(3'b010, 32'h104, 32'hCAFEF00D, wb);
      n_tests++;
      if (wb !== 32'hCAFEF00D || WB_Reg_Write !== 1'b1) begin
         n_fail++; $display("FAIL rst_busy_next_lw: data=%h rw=%b, required cafef00d 1", wb, WB_Reg_Write);
      end
   endtask

   initial begin
      test_reset();
      test_alu_op();
      test_lb();
      test_load_ext();
      test_store();
      test_fault();
      test_timeout();
      test_reset_busy();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: ACK_TIMEOUT, 16, the maximum number of BUSY cycles spent waiting for mem_ack; legal range 2..255.
REQ-002 clk  in  1  sole clock; all state updates on negedge clk, matching the pipeline stage registers.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 Mem_Read_in, Mem_Write_in, Mem_to_Reg_in, Reg_Write_in  in  1 each  MEM-stage control bits from the execute/memory stage register.
REQ-005 RD_in  in  5  destination register index.
REQ-006 ALU_Result_in  in  32  byte address for loads/stores; result value for non-memory ops.
REQ-007 B_in  in  32  store data.
REQ-008 funct3_in  in  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 stall  out  1  hold request to upstream stage registers and PC.
REQ-010 fault  out  1  one-cycle pulse on misaligned access, illegal access, or timeout.
REQ-011 mem_req, mem_we  out  1 each  memory request and write strobe.
REQ-012 mem_addr  out  32  word-aligned address (ALU_Result_in & ~3).
REQ-013 mem_wdata  out  32  lane-replicated store data.
REQ-014 mem_be  out  4  byte enables.
REQ-015 mem_rdata  in  32  read data, valid when mem_ack=1.
REQ-016 mem_ack  in  1  memory completion.
REQ-017 WB_Reg_Write, WB_Mem_to_Reg  out  1 each; WB_RD  out  5; WB_data  out  32  registered write-back bundle.

Function
REQ-018 FSM states SHALL be IDLE, BUSY, DONE.
REQ-019 Access definition: Mem_Read_in XOR Mem_Write_in. Illegal: both bits set, or funct3 is not one of the five legal codes. Misaligned: H/HU with addr[0]=1, or W with addr[1:0]≠00.
REQ-020 IDLE, legal aligned access: stall=1 combinationally; capture address, data, be, controls and funct3; next state BUSY.
REQ-021 IDLE, illegal or misaligned access: fault=1 this cycle; stall=0; no memory request; WB bundle loads a bubble (all zero).
REQ-022 IDLE, non-access op: stall=0; WB bundle loads Reg_Write_in, Mem_to_Reg_in, RD_in and ALU_Result_in at the clock edge.
REQ-023 BUSY: stall=1; mem_req=1 with mem_we, mem_addr, mem_wdata and mem_be held stable; wait counter increments each cycle.
REQ-024 BUSY exit on mem_ack=1: capture the extended load data; next state DONE. Minimum latency is 1 BUSY cycle.
REQ-025 BUSY timeout: counter = ACK_TIMEOUT-1 with no ack: next state DONE with a timeout flag set; mem_req drops.
REQ-026 DONE: stall=0; inputs ignored; fault=1 if the timeout flag is set; next state IDLE.
REQ-027 DONE, WB bundle update: loads the captured load result with its controls. A store, or any timeout, loads a bubble instead.
REQ-028 Bubble cycles: WB bundle loads a bubble at every edge while stall=1.
REQ-029 Stores: mem_be = 0001<<addr[1:0] for B, 0011<<addr[1:0] for H, 1111 for W. mem_wdata replicates B_in[7:0] ×4, B_in[15:0] ×2, or B_in whole for B, H and W respectively.
REQ-030 Loads: select the lane by addr[1:0]. B/H sign-extend; BU/HU zero-extend; W passes through unchanged.
REQ-031 mem_ack in IDLE or DONE SHALL be ignored.
REQ-032 mem_req, mem_we and mem_be SHALL be 0 outside BUSY.

Reset
REQ-033 rst=1 at an edge: state IDLE; counter and timeout flag 0; all outputs 0 (mem_addr, mem_wdata and WB_data included).
REQ-034 Reset in BUSY: the request is abandoned and mem_req is 0 in the next cycle. No write-back or fault results from the abandoned access.

Verification
REQ-035 LB, addr 0x103, ack after 1 BUSY cycle, mem_rdata 0x80FF1234 -> mem_addr 0x100, stall high for 2 cycles, WB_data 0xFFFFFF80, WB_Reg_Write=1.
REQ-036 SH, addr 0x102, B_in 0x0000ABCD -> mem_be 1100, mem_wdata 0xABCDABCD, mem_we=1, WB_Reg_Write=0.
REQ-037 LW at addr 0x101 -> fault pulse, stall=0, mem_req never set, WB bundle all zero.
REQ-038 LW with mem_ack never asserted, ACK_TIMEOUT=16 -> 16 BUSY cycles, then DONE with fault=1, then IDLE; late ack ignored.
REQ-039 ADD result 0x12345678, rd=5, Reg_Write=1 -> WB_data 0x12345678, WB_RD 5 one edge later, stall never set.
REQ-040 rst asserted on the 3rd BUSY cycle -> mem_req=0 in the next cycle, all outputs 0, and the next LW completes normally.
